io_port_bridge: RTL
===================

// Module: io_port_bridge
// PURPOSE
//  Memory-mapped I/O bridge downstream of the MIPS core's data bus, in parallel with DataMemory.
//  Decodes a 16-byte window, holds the PortOut register and samples the 8-bit PortIn pins.
//  Pushes byte stores into a TX FIFO drained over valid/ready, and exposes sticky status.
//  The top level selects ReadData from this block whenever IOSel=1, else from DataMemory.
// PARAMETERS
//  BASE_ADDR   32'h1001_0020  word-aligned base of the 4-register window
//  FIFO_DEPTH  4              TX FIFO entries; power of 2, 2..64
// PORTS
//  clk        in   1   single clock, rising edge
//  reset      in   1   asynchronous, active-high
//  Address    in   32  core data address (ALU result)
//  WriteData  in   32  core store data
//  MemWrite   in   1   store strobe, sampled on clk rise
//  MemRead    in   1   load strobe
//  ReadData   out  32  load data, combinational from registers
//  IOSel      out  1   Address hits the window (aligned); steers the top-level read mux
//  PortIn     in   8   asynchronous external pins
//  PortOut    out  32  output register
//  FifoData   out  8   FIFO head byte
//  FifoValid  out  1   FIFO not empty
//  FifoReady  in   1   consumer accepts the head byte when FifoValid & FifoReady at clk rise
// BEHAVIOUR
//  Register map (offset : access):
//    +0x0 PORT_OUT : R/W
//    +0x4 PORT_IN  : R, {24'b0, sync PortIn}
//    +0x8 FIFO     : W, push WriteData[7:0]; reads return 0
//    +0xC STATUS   : R, read clears sticky bits
//  Decode: IOSel = (Address[31:4]==BASE_ADDR[31:4]) && (Address[1:0]==0). Misaligned accesses never hit.
//  Writes to read-only offsets are ignored. Reads while IOSel=0 return 32'b0.
//  STATUS layout: [0] CHG sticky, [1] OVF sticky, [2] full, [3] empty, [15:8] count, rest 0.
//  Reset values: PortOut=0, both sync FFs=0, prev=0, CHG=0, OVF=0, pointers/count=0;
//    hence FifoValid=0, FifoData=0, and STATUS reads 32'h0000_0008.
//  Latency:
//    - PORT_OUT write is visible on PortOut the cycle after the store edge.
//    - PortIn reaches PORT_IN 2 edges after it settles (2-FF synchronizer).
//    - CHG sets 1 edge after the synced value differs from prev; prev updates every cycle.
//  Read-to-clear: on an edge with MemRead & IOSel & offset 0xC, CHG and OVF clear.
//    The load in that same cycle returns the pre-clear value.
//    A set event on that same edge wins: the bit stays 1.
//  FIFO:
//    - push = MemWrite & IOSel & offset 0x8; pop = FifoValid & FifoReady.
//    - The push is accepted if !full | pop; full plus simultaneous pop keeps count unchanged.
//    - push & full & !pop drops the byte, sets OVF, and leaves count unchanged.
//    - pop on empty is impossible (FifoValid=0).
//    - Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH (count width = clog2(DEPTH)+1).
//    - FifoData is registered/RAM head, stable while FifoValid & !FifoReady.
//  MemRead & MemWrite together: the write occurs and ReadData still shows pre-edge contents.
//  Asserting reset mid-transfer empties the FIFO immediately (FifoValid drops asynchronously),
//    and PortOut returns to 0.
// STRUCTURE
//  io_port_pkg: register offsets (OFF_PORT_OUT/IN/FIFO/STATUS), STATUS bit indices, default BASE_ADDR.
//  Sub-module io_tx_fifo (param WIDTH=8, DEPTH):
//    push/pop/full/empty/count, circular buffer with wrap pointers.
//  Top of the block holds the decode, the PORT_OUT register, the synchronizer/change detect,
//    the sticky bits and the read mux.
// TESTING
//  1. Reset, then load STATUS -> 32'h0000_0008.
//     PortOut=0, FifoValid=0.
//  2. Store 32'hDEAD_BEEF to BASE+0x0 -> PortOut=DEAD_BEEF next cycle.
//     Load BASE+0x0 returns it. Store to BASE+0x4 leaves PORT_IN unchanged.
//  3. PortIn 00->A5 -> PORT_IN reads 32'h0000_00A5 from edge 2.
//     STATUS[0]=1 afterwards. A second STATUS read returns [0]=0.
//     A change landing on the clearing edge leaves [0]=1.
//  4. FifoReady=0, push 0x11,0x22,0x33,0x44,0x55 -> count=4, full=1, OVF=1.
//     Then FifoReady=1 drains 11,22,33,44 in order over 4 cycles, then FifoValid=0.
//  5. FIFO full, FifoReady=1, push 0x66 on the same edge as a pop -> count stays 4, OVF stays 0.
//     0x66 emerges last after wrap-around.
//  6. Misaligned store to BASE+0x2, or store to BASE+0x10 -> IOSel=0, no state change.
//     Reset asserted mid-drain -> FifoValid=0 immediately.

Source files
------------

// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - shared register offsets, STATUS bit positions and default window base for the I/O bridge
package io_port_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0020;

  // Register select is the word index Address[3:2] inside the 16-byte window
  typedef enum logic [1:0] {
    OFF_PORT_OUT = 2'd0,
    OFF_PORT_IN  = 2'd1,
    OFF_FIFO     = 2'd2,
    OFF_STATUS   = 2'd3
  } reg_off_e;

  localparam int STAT_CHG     = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_EMPTY   = 3;
  localparam int STAT_CNT_LSB = 8;

endpackage

// File: rtl/io_tx_fifo.sv
// rtl/io_tx_fifo.sv - circular-buffer TX FIFO with wrap pointers, occupancy count and overflow strobe
module io_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop, accept;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign valid_o = !empty_o;
  assign pop     = pop_i && !empty_o;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands
  assign accept  = push_i && (!full_o || pop);
  assign ovf_o   = push_i && full_o && !pop;
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - memory-mapped I/O window: PORT_OUT register, synced PORT_IN, TX FIFO push and sticky STATUS
module io_port_bridge
  import io_port_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        IOSel,
  input  logic [7:0]  PortIn,
  output logic [31:0] PortOut,
  output logic [7:0]  FifoData,
  output logic        FifoValid,
  input  logic        FifoReady
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reg_off_e      off;
  logic          wr_en, rd_en, push, rd_clr, chg_set, ovf_set;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [31:0]   status;

  logic [31:0] port_out_q, port_out_d;
  logic [7:0]  sync1_q, sync1_d;
  logic [7:0]  sync2_q, sync2_d;
  logic [7:0]  prev_q, prev_d;
  logic        chg_q, chg_d;
  logic        ovf_q, ovf_d;

  assign off    = reg_off_e'(Address[3:2]);
  assign IOSel  = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign wr_en  = MemWrite && IOSel;
  assign rd_en  = MemRead && IOSel;
  assign push   = wr_en && (off == OFF_FIFO);
  assign rd_clr = rd_en && (off == OFF_STATUS);
  assign chg_set = (sync2_q != prev_q);

  io_tx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  (WriteData[7:0]),
    .pop_i   (FifoReady),
    .data_o  (FifoData),
    .valid_o (FifoValid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .ovf_o   (ovf_set)
  );

  always_comb begin
    port_out_d = (wr_en && (off == OFF_PORT_OUT)) ? WriteData : port_out_q;
    sync1_d    = PortIn;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    // Set beats read-clear so an event on the clearing edge is never lost
    chg_d      = chg_set || (chg_q && !rd_clr);
    ovf_d      = ovf_set || (ovf_q && !rd_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      chg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      chg_q      <= chg_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    status                          = '0;
    status[STAT_CHG]                = chg_q;
    status[STAT_OVF]                = ovf_q;
    status[STAT_FULL]               = fifo_full;
    status[STAT_EMPTY]              = fifo_empty;
    status[STAT_CNT_LSB +: 8]       = 8'(fifo_count);
  end

  always_comb begin
    ReadData = '0;
    if (IOSel) begin
      case (off)
        OFF_PORT_OUT: ReadData = port_out_q;
        OFF_PORT_IN:  ReadData = {24'b0, sync2_q};
        OFF_STATUS:   ReadData = status;
        default:      ReadData = '0;
      endcase
    end
  end

  assign PortOut = port_out_q;

endmodule
